// File: rtl/fifo_burst_reader.sv
// Burst reader: pops a programmed number of words from a first-word-fall-through
// FIFO and presents them on a registered valid/ready stream with last/done marking.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  pop;
  logic                  accept;

  assign accept = m_valid_q && m_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    pop       = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = burst_len;
          state_d = (burst_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Pop only when the output register is free or being drained this cycle.
        pop = !fifo_empty && (cnt_q != '0) && (!m_valid_q || m_ready);
        if (accept && m_last_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      m_data_d  = fifo_rd_data;
      m_valid_d = 1'b1;
      m_last_d  = (cnt_q == LEN_WIDTH'(1));
      cnt_d     = cnt_q - LEN_WIDTH'(1);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_data     = m_data_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FWFT FIFO, table of burst scenarios,
// scoreboard of expected beats, and hand sequences for back-pressure and reset.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int preload;
    int len;
    int push_delay;
    int push_cnt;
    int exp_pops;
    int exp_left;
    bit contig;
    int base;
  } vec_t;

  logic [DW-1:0] fifo_q[$];
  beat_t         sb[$];
  vec_t          vecs[6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, pops, done_cnt, exp_done_at, sb_need, first_pop, last_pop, last_acc;
  logic          hold_v;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fifo_drive();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    if (sb_need > 0) begin
      sb.push_back(beat_t'{data: w, last: (sb_need == 1)});
      sb_need--;
    end
    fifo_drive();
  endtask

  // One clock: sample/check just after the falling edge, update FIFO after the rising edge.
  task automatic tick();
    logic rd;
    #1;
    check("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 0);
    if (hold_v) begin
      check("hold_valid", 32'(m_valid), 1);
      check("hold_data", 32'(m_data), 32'(hold_d));
      check("hold_last", 32'(m_last), 32'(hold_l));
    end
    if (m_valid && m_ready) begin
      check("beat_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", 32'(m_data), 32'(e.data));
        check("beat_last", 32'(m_last), 32'(e.last));
        if (e.last) begin
          last_acc    = cyc;
          exp_done_at = cyc + 1;
        end
      end
    end
    if (done) begin
      done_cnt++;
      check("done_timing", cyc, exp_done_at);
    end
    if (fifo_rd_en) begin
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end
    hold_v = m_valid && !m_ready;
    hold_d = m_data;
    hold_l = m_last;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd) void'(fifo_q.pop_front());
    fifo_drive();
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_burst(input int len, input int preload, input int base);
    pops        = 0;
    done_cnt    = 0;
    exp_done_at = -1;
    last_acc    = -1;
    first_pop   = -1;
    last_pop    = -1;
    hold_v      = 1'b0;
    sb.delete();
    sb_need = len;
    for (int i = 0; i < fifo_q.size() && sb_need > 0; i++) begin
      sb.push_back(beat_t'{data: fifo_q[i], last: (sb_need == 1)});
      sb_need--;
    end
    for (int i = 0; i < preload; i++) push_word(DW'(base + 17 * i));
    start     = 1'b1;
    burst_len = LW'(len);
    if (len == 0) exp_done_at = cyc + 1;
    tick();
    start     = 1'b0;
    burst_len = LW'($urandom);
  endtask

  task automatic run_until_done(input int s, input int len, input int push_delay,
                                input int push_cnt, input int base, input int preload,
                                input int exp_pops, input int exp_left, input bit contig);
    int post;
    post = 0;
    while (post < 2 && (cyc - s) < len + 40) begin
      if (push_cnt > 0 && (cyc - s) == push_delay)
        for (int k = 0; k < push_cnt; k++) push_word(DW'(base + 17 * (preload + k)));
      tick();
      if (done_cnt > 0) post++;
    end
    #1;
    check("done_pulses", done_cnt, 1);
    check("pop_count", pops, exp_pops);
    check("fifo_left", fifo_q.size(), exp_left);
    check("sb_drained", sb.size(), 0);
    check("busy_after", 32'(busy), 0);
    check("valid_after", 32'(m_valid), 0);
    if (contig) check("contiguous_pops", last_pop - first_pop, exp_pops - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r;
    vecs[0] = '{4,   4,   0, 0, 4,   0, 1'b1, 'hA1};
    vecs[1] = '{8,   3,   0, 0, 3,   5, 1'b1, 'h1000};
    vecs[2] = '{0,   2,   5, 2, 2,   0, 1'b0, 'h2000};
    vecs[3] = '{2,   0,   0, 0, 0,   2, 1'b0, 'h3000};
    vecs[4] = '{3,   1,   0, 0, 1,   2, 1'b1, 'h4000};
    vecs[5] = '{260, 255, 0, 0, 255, 5, 1'b1, 'h5000};

    cyc = 0; sb_need = 0; hold_v = 1'b0;
    rst_n = 1'b0; start = 1'b0; burst_len = '0; m_ready = 1'b1;
    fifo_q.push_back(16'h55AA);
    fifo_drive();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    fifo_q.delete();
    fifo_drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      fifo_q.delete();
      fifo_drive();
      m_ready = 1'b1;
      s = cyc;
      start_burst(vecs[v].len, vecs[v].preload, vecs[v].base);
      run_until_done(s, vecs[v].len, vecs[v].push_delay, vecs[v].push_cnt, vecs[v].base,
                     vecs[v].preload, vecs[v].exp_pops, vecs[v].exp_left, vecs[v].contig);
      @(negedge clk);
    end

    // Back-pressure: first beat held for five cycles, then the rest stream without bubbles.
    fifo_q.delete();
    fifo_drive();
    m_ready = 1'b0;
    s = cyc;
    start_burst(4, 4, 'h6000);
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    check("bp_first_valid", 32'(m_valid), 1);
    repeat (5) tick();
    check("bp_single_pop", pops, 1);
    m_ready = 1'b1;
    r = cyc;
    run_until_done(s, 4 + 10, 0, 0, 0, 0, 4, 0, 1'b0);
    check("bp_no_bubble", last_acc - r, 3);
    @(negedge clk);

    // Start while busy is ignored; reset mid-burst drops everything without a done pulse.
    fifo_q.delete();
    fifo_drive();
    m_ready = 1'b1;
    s = cyc;
    start_burst(6, 8, 'h7000);
    start     = 1'b1;
    burst_len = LW'(1);
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rst_seq_pops", pops, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(m_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_last", 32'(m_last), 0);
    check("midrst_data", 32'(m_data), 0);
    check("midrst_rd_en", 32'(fifo_rd_en), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", 32'(done), 0);
      @(negedge clk);
      cyc++;
    end
    check("midrst_fifo_kept", fifo_q.size(), 5);
    rst_n = 1'b1;
    @(negedge clk);
    cyc++;
    s = cyc;
    start_burst(2, 0, 0);
    run_until_done(s, 2, 0, 0, 0, 0, 2, 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
